tfifo_dataless: RTL and testbench
=================================

// Module: tfifo_dataless
// PURPOSE
// - Dataless elastic FIFO that stores up to NUM_SLOTS control tokens as an occupancy count.
// - Sits directly upstream of cond_br_dataless on its data or condition channel.
// - Absorbs rate mismatch between the producer and the branch.
// - Cuts the ready path: ins_ready never depends combinationally on outs_ready.
// PARAMETERS
// - NUM_SLOTS  4                              token capacity; legal range >= 1
// - CNT_W      $clog2(NUM_SLOTS+1) (derived)  occupancy counter width
// PORTS
// - clk         in   1      single clock; all state on rising edge
// - rst         in   1      reset, synchronous, active-high
// - ins_valid   in   1      upstream token offered
// - ins_ready   out  1      FIFO can accept a token this cycle
// - outs_valid  out  1      token available to downstream (e.g. cond_br data_valid)
// - outs_ready  in   1      downstream accepts token
// - occupancy   out  CNT_W  tokens currently stored (registered count)
// BEHAVIOUR
// - State: count register, 0..NUM_SLOTS. full = (count==NUM_SLOTS), empty = (count==0).
// - Reset: rst high at a rising edge -> count=0.
// - Reset: while rst is high, ins_ready=0 and outs_valid=0 (forced); occupancy shows the register.
// - Reset: first cycle after rst drops -> ins_ready=1, outs_valid=0, occupancy=0.
// - Reset mid-operation discards all stored tokens; no token is emitted in the rst cycle.
// - ins_ready = !rst & !full. Combinational from state only.
// - push = ins_valid & ins_ready; pop = outs_valid & outs_ready.
// - Non-bypass: outs_valid = !rst & !empty. Latency 1 cycle: a token pushed in cycle N is visible in cycle N+1.
// - Count update per edge:
//   - push & !pop -> +1
//   - pop & !push -> -1
//   - both or neither -> unchanged
// - Full: ins_ready=0, so a push is impossible even if outs_ready=1 in the same cycle.
//   - Pop still succeeds; ins_ready rises the next cycle.
// - Empty: outs_valid=0 (non-bypass); a simultaneous push takes count 0 -> 1.
// - NUM_SLOTS=1: behaves as a half-rate one-slot buffer; full and !empty coincide.
// - No wrap-around: count saturates structurally because push is gated by full and pop by empty.
// - Handshake: outs_valid, once high, stays high until pop (count only decreases via pop).
//   - ins_valid is not required to be sticky.
// - Elaboration error if NUM_SLOTS < 1.
// CONFIGURATION
// - Macro TFIFO_DATALESS_BYPASS_EN.
// - Defined: when empty and not in reset, outs_valid = ins_valid (combinational pass-through).
//   - If empty & ins_valid & outs_ready: the token passes straight through and count stays 0.
//   - If empty & ins_valid & !outs_ready: the token is stored (count -> 1).
//   - Zero-cycle latency when empty; ins_ready is still !rst & !full.
//   - occupancy excludes bypassed tokens.
// - Undefined: strict registered behaviour as above; minimum latency 1 cycle.
// TESTING
// - Reset: hold rst 2 cycles with ins_valid=1 -> ins_ready=0, outs_valid=0.
//   - Next cycle: ins_ready=1, occupancy=0.
// - Fill: NUM_SLOTS=4, ins_valid=1, outs_ready=0 for 6 cycles -> 4 pushes accepted.
//   - occupancy goes 1,2,3,4; ins_ready=0 from cycle 5; outs_valid=1 from cycle 2.
// - Drain: from full, ins_valid=0, outs_ready=1 -> 4 pops on 4 consecutive cycles.
//   - occupancy goes 3,2,1,0; outs_valid=0 after; ins_ready=1 from the first pop's next cycle.
// - Streaming: count=2, ins_valid=1 and outs_ready=1 for 10 cycles.
//   - 10 pushes and 10 pops; occupancy stays at 2.
// - Full plus ready: count=4, ins_valid=1, outs_ready=1 -> cycle 1 pop only (count=3).
//   - Cycle 2 onward: push+pop, count stays 3.
// - Bypass (macro defined): empty, ins_valid=1, outs_ready=1 -> outs_valid=1 in the same cycle.
//   - occupancy stays 0; without the macro outs_valid=0 in that cycle and occupancy=1 the next.

Source files
------------

// File: rtl/tfifo_dataless.sv
// Dataless elastic FIFO: tracks up to NUM_SLOTS control tokens as an occupancy count.
// Define TFIFO_DATALESS_BYPASS_EN for zero-latency pass-through when empty.
module tfifo_dataless #(
    parameter int NUM_SLOTS = 4,
    localparam int CNT_W    = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic             outs_valid,
    input  logic             outs_ready,
    output logic [CNT_W-1:0] occupancy
);

    generate
        if (NUM_SLOTS < 1) begin : g_bad_param
            $error("tfifo_dataless: NUM_SLOTS must be >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_SLOTS);

    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count == MAX_CNT);
    assign empty = (count == '0);

    // Ready depends only on state, so the downstream ready path is cut here.
    assign ins_ready = !rst && !full;

`ifdef TFIFO_DATALESS_BYPASS_EN
    assign outs_valid = !rst && (!empty || ins_valid);
`else
    assign outs_valid = !rst && !empty;
`endif

    // A bypassed token is both pushed and popped, leaving count unchanged.
    assign push = ins_valid && ins_ready;
    assign pop  = outs_valid && outs_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_tfifo_dataless.sv
// Directed self-checking bench for tfifo_dataless with NUM_SLOTS=4.
// Expectations adapt to TFIFO_DATALESS_BYPASS_EN when it is defined.
module tb_tfifo_dataless;

    localparam int NUM_SLOTS = 4;
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1);
`ifdef TFIFO_DATALESS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             ins_valid;
    logic             ins_ready;
    logic             outs_valid;
    logic             outs_ready;
    logic [CNT_W-1:0] occupancy;

    int checks;
    int errors;

    tfifo_dataless #(.NUM_SLOTS(NUM_SLOTS)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cycle: drive inputs, settle, check pre-edge outputs, then step past the edge.
    task automatic test_reset();
        rst = 1'b1; ins_valid = 1'b1; outs_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ins_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_ins_ready cyc=%0d got %b exp 0", k, ins_ready);
            end
            checks++;
            if (outs_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_outs_valid cyc=%0d got %b exp 0", k, outs_valid);
            end
            checks++;
            if (occupancy !== 3'd0) begin
                errors++; $display("[TB] FAIL reset_occ cyc=%0d got %0d exp 0", k, occupancy);
            end
        end
        rst = 1'b0; ins_valid = 1'b0;
        #1;
        checks++;
        if (ins_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL post_reset_ins_ready got %b exp 1", ins_ready);
        end
        checks++;
        if (outs_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_outs_valid got %b exp 0", outs_valid);
        end
        checks++;
        if (occupancy !== 3'd0) begin
            errors++; $display("[TB] FAIL post_reset_occ got %0d exp 0", occupancy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        logic       exp_ir [6] = '{1, 1, 1, 1, 0, 0};
        logic       exp_ov [6] = '{BYP, 1, 1, 1, 1, 1};
        logic [2:0] exp_pre[6] = '{0, 1, 2, 3, 4, 4};
        logic [2:0] exp_post[6] = '{1, 2, 3, 4, 4, 4};
        ins_valid = 1'b1; outs_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (ins_ready !== exp_ir[k]) begin
                errors++; $display("[TB] FAIL fill_ins_ready cyc=%0d got %b exp %b", k + 1, ins_ready, exp_ir[k]);
            end
            checks++;
            if (outs_valid !== exp_ov[k]) begin
                errors++; $display("[TB] FAIL fill_outs_valid cyc=%0d got %b exp %b", k + 1, outs_valid, exp_ov[k]);
            end
            checks++;
            if (occupancy !== exp_pre[k]) begin
                errors++; $display("[TB] FAIL fill_occ_pre cyc=%0d got %0d exp %0d", k + 1, occupancy, exp_pre[k]);
            end
            @(posedge clk); #1;
            checks++;
            if (occupancy !== exp_post[k]) begin
                errors++; $display("[TB] FAIL fill_occ_post cyc=%0d got %0d exp %0d", k + 1, occupancy, exp_post[k]);
            end
        end
    endtask

    task automatic test_drain();
        logic       exp_ir [4] = '{0, 1, 1, 1};
        logic [2:0] exp_post[4] = '{3, 2, 1, 0};
        ins_valid = 1'b0; outs_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (outs_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL drain_outs_valid cyc=%0d got %b exp 1", k + 1, outs_valid);
            end
            checks++;
            if (ins_ready !== exp_ir[k]) begin
                errors++; $display("[TB] FAIL drain_ins_ready cyc=%0d got %b exp %b", k + 1, ins_ready, exp_ir[k]);
            end
            @(posedge clk); #1;
            checks++;
            if (occupancy !== exp_post[k]) begin
                errors++; $display("[TB] FAIL drain_occ cyc=%0d got %0d exp %0d", k + 1, occupancy, exp_post[k]);
            end
        end
        #1;
        checks++;
        if (outs_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL drain_empty_outs_valid got %b exp 0", outs_valid);
        end
        checks++;
        if (ins_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL drain_empty_ins_ready got %b exp 1", ins_ready);
        end
    endtask

    task automatic test_streaming();
        // Preload two tokens with downstream stalled.
        ins_valid = 1'b1; outs_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (occupancy !== 3'd2) begin
            errors++; $display("[TB] FAIL stream_preload_occ got %0d exp 2", occupancy);
        end
        outs_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (ins_ready !== 1'b1 || outs_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL stream_handshake cyc=%0d got ir=%b ov=%b exp ir=1 ov=1", k + 1, ins_ready, outs_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (occupancy !== 3'd2) begin
                errors++; $display("[TB] FAIL stream_occ cyc=%0d got %0d exp 2", k + 1, occupancy);
            end
        end
    endtask

    task automatic test_full_plus_ready();
        logic       exp_ir [4] = '{0, 1, 1, 1};
        logic [2:0] exp_post[4] = '{3, 3, 3, 3};
        ins_valid = 1'b1; outs_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (occupancy !== 3'd4) begin
            errors++; $display("[TB] FAIL fpr_preload_occ got %0d exp 4", occupancy);
        end
        outs_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (ins_ready !== exp_ir[k]) begin
                errors++; $display("[TB] FAIL fpr_ins_ready cyc=%0d got %b exp %b", k + 1, ins_ready, exp_ir[k]);
            end
            checks++;
            if (outs_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL fpr_outs_valid cyc=%0d got %b exp 1", k + 1, outs_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (occupancy !== exp_post[k]) begin
                errors++; $display("[TB] FAIL fpr_occ cyc=%0d got %0d exp %0d", k + 1, occupancy, exp_post[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; ins_valid = 1'b1; outs_ready = 1'b1;
        #1;
        checks++;
        if (outs_valid !== 1'b0 || ins_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_forced got ir=%b ov=%b exp ir=0 ov=0", ins_ready, outs_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (occupancy !== 3'd0) begin
            errors++; $display("[TB] FAIL midrst_occ got %0d exp 0", occupancy);
        end
        rst = 1'b0; ins_valid = 1'b0; outs_ready = 1'b0;
        #1;
        checks++;
        if (ins_ready !== 1'b1 || outs_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_release got ir=%b ov=%b exp ir=1 ov=0", ins_ready, outs_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bypass();
        logic [2:0] exp_occ;
        exp_occ = BYP ? 3'd0 : 3'd1;
        ins_valid = 1'b1; outs_ready = 1'b1;
        #1;
        checks++;
        if (outs_valid !== BYP) begin
            errors++; $display("[TB] FAIL bypass_outs_valid got %b exp %b", outs_valid, BYP);
        end
        @(posedge clk); #1;
        ins_valid = 1'b0; outs_ready = 1'b0;
        checks++;
        if (occupancy !== exp_occ) begin
            errors++; $display("[TB] FAIL bypass_occ got %0d exp %0d", occupancy, exp_occ);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; ins_valid = 1'b0; outs_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_full_plus_ready();
        test_mid_reset();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
